forward_unit: RTL and testbench
===============================

FORWARD_UNIT -- requirements
Module: forward_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: operand and result width.
REQ-002 SHALL have parameter REG_NUM, default 32: architectural registers; index width RW = $clog2(REG_NUM).
REQ-003 SHALL have parameter NUM_RS, default 2: source-operand read ports.
REQ-004 SHALL have parameter MAX_OUT, default 4: maximum outstanding loads (>=1).
REQ-005 SHALL have one clock and a synchronous, active-high reset; the ports are listed below.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 rs_idx  in  NUM_RS x RW  source register per port.
REQ-009 rs_used  in  NUM_RS  port carries a live operand.
REQ-010 file_data  in  NUM_RS x DATA_WIDTH  register-file read data per port.
REQ-011 ex_wr_en, ex_is_load, ex_rd, ex_data  in  1,1,RW,DATA_WIDTH  EX-stage producer.
REQ-012 mm_wr_en, mm_rd, mm_data  in  1,RW,DATA_WIDTH  MM-stage ALU producer.
REQ-013 wb_wr_en, wb_rd, wb_data  in  1,RW,DATA_WIDTH  WB-stage producer (used only when the macro in REQ-033 is defined).
REQ-014 ld_issue_valid, ld_issue_rd  in  1,RW  load issued to memory.
REQ-015 ld_issue_ready  out  1  a load may be accepted.
REQ-016 mem_resp_valid, mem_resp_rd, mem_resp_data  in  1,RW,DATA_WIDTH  load data return.
REQ-017 rs_data  out  NUM_RS x DATA_WIDTH  forwarded operand per port.
REQ-018 stall  out  1  hold the decode stage this cycle.
REQ-019 out_cnt  out  $clog2(MAX_OUT+1)  outstanding load count.
REQ-020 resp_err  out  1  sticky flag: response received with no load outstanding.

Function
REQ-021 rs_data per port SHALL be combinational, using the first matching source in this order: rs_idx==0 -> 0; ex_wr_en & !ex_is_load & ex_rd==rs -> ex_data; mm_wr_en & mm_rd==rs -> mm_data; mem_resp_valid & mem_resp_rd==rs -> mem_resp_data; wb match -> wb_data; otherwise file_data.
REQ-022 Scoreboard: one busy bit per register; bit 0 SHALL never be set.
REQ-023 An accepted issue (ld_issue_valid & ld_issue_ready) with rd!=0 SHALL set busy[rd] at the next edge.
REQ-024 mem_resp_valid SHALL clear busy[mem_resp_rd] at the next edge; if set and clear target the same register in one cycle, set SHALL win.
REQ-025 A port stall SHALL be raised when rs_used & rs!=0 and either (a) busy[rs] & !(mem_resp_valid & mem_resp_rd==rs), or (b) ex_wr_en & ex_is_load & ex_rd==rs (load-use); stall is the OR of all port stalls.
REQ-026 out_cnt SHALL increment on an accepted issue (including rd==0), decrement on mem_resp_valid, and stay unchanged when both occur.
REQ-027 ld_issue_ready SHALL be (out_cnt < MAX_OUT), combinational from registered state; when ld_issue_ready is low, ld_issue_valid SHALL not change state.
REQ-028 mem_resp_valid with out_cnt==0 and no same-cycle accepted issue: out_cnt SHALL hold at 0, resp_err SHALL set (sticky until reset), and busy SHALL still clear.
REQ-029 Latency: forwarding and stall SHALL have 0 cycles; scoreboard effects SHALL be visible 1 cycle after the issue or response.

Reset
REQ-030 On rst at a clock edge: all busy bits, out_cnt and resp_err SHALL go to 0, so ld_issue_ready=1 and stall is driven only by load-use.
REQ-031 A reset taken mid-operation SHALL discard outstanding loads; later responses SHALL set resp_err per REQ-028.

Configuration
REQ-032 Exactly one feature is compile-time configurable, by the macro in REQ-033.
REQ-033 With FORWARD_UNIT_WB_BYPASS_EN defined: the WB source SHALL be included per REQ-021. Without it: wb_* SHALL be ignored and the file_data path taken instead, with the register file assumed write-before-read.

Structure
REQ-034 A shared package forward_pkg SHALL hold the fwd_src_t enum (ZERO, EX, MM, MEM, WB, FILE) and the default parameter constants.
REQ-035 Per-port selection SHALL be a sub-module fwd_port_sel, instantiated NUM_RS times, taking the decoded match vector and returning data and fwd_src_t.

Verification
REQ-036 rs0=5, ex_wr_en=1, ex_rd=5, ex_data=0xAA, mm also writes 5 with 0xBB -> rs_data[0]=0xAA, stall=0.
REQ-037 Issue load rd=7; next cycle rs1=7 used -> stall=1; mem_resp rd=7, data 0x1234 -> same cycle rs_data[1]=0x1234, stall=0; busy[7] clear after the edge.
REQ-038 MAX_OUT=4, issue 4 loads -> out_cnt=4, ld_issue_ready=0; one response -> out_cnt=3, ld_issue_ready=1.
REQ-039 rs=0 with every producer targeting rd=0 -> rs_data=0, stall=0; issue load rd=0 -> out_cnt increments, no busy bit set.
REQ-040 Response with out_cnt=0 -> resp_err=1 and held; assert rst -> resp_err=0, out_cnt=0.
REQ-041 Same cycle: issue rd=9 and mem_resp rd=9 -> busy[9]=1 after the edge, out_cnt unchanged.

Source files
------------

// File: rtl/forward_pkg.sv
// ---------------------------------------------------------------------------
// forward_pkg
// Shared definitions for the operand forwarding unit.
//   - default parameter constants for forward_unit
//   - fwd_src_t: which producer supplied a forwarded operand
//   - bit positions of the per-port decoded match vector handed to
//     fwd_port_sel
// Optional feature macro used by the files importing this package:
//   FORWARD_UNIT_WB_BYPASS_EN  (enables the WB-stage bypass source)
// ---------------------------------------------------------------------------
package forward_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_REG_NUM    = 32;
  localparam int DEFAULT_NUM_RS     = 2;
  localparam int DEFAULT_MAX_OUT    = 4;

  typedef enum logic [2:0] {
    ZERO,
    EX,
    MM,
    MEM,
    WB,
    FILE
  } fwd_src_t;

  // Match vector layout, listed in forwarding priority order
  localparam int HIT_ZERO = 0;
  localparam int HIT_EX   = 1;
  localparam int HIT_MM   = 2;
  localparam int HIT_MEM  = 3;
  localparam int HIT_WB   = 4;
  localparam int NUM_HITS = 5;

endpackage

// File: rtl/fwd_port_sel.sv
// ---------------------------------------------------------------------------
// fwd_port_sel
// Priority multiplexer for one source-operand read port. The caller decodes
// which producers match the port's register; this block picks the first
// match in priority order (zero register, EX, MM, memory response, WB) and
// falls back to the register-file read data.
// Ports:
//   hit        in   NUM_HITS    decoded match vector (bit layout in forward_pkg)
//   ex_data    in   DATA_WIDTH  EX-stage ALU result
//   mm_data    in   DATA_WIDTH  MM-stage ALU result
//   mem_data   in   DATA_WIDTH  load data returning from memory
//   wb_data    in   DATA_WIDTH  WB-stage result
//   file_data  in   DATA_WIDTH  register-file read data
//   data       out  DATA_WIDTH  selected operand
//   src        out  fwd_src_t   which source was selected
// ---------------------------------------------------------------------------
module fwd_port_sel
  import forward_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [NUM_HITS-1:0]   hit,
  input  logic [DATA_WIDTH-1:0] ex_data,
  input  logic [DATA_WIDTH-1:0] mm_data,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [DATA_WIDTH-1:0] file_data,
  output logic [DATA_WIDTH-1:0] data,
  output fwd_src_t              src
);

  // First match wins; the youngest producer has the freshest value, and the
  // zero register always reads as zero regardless of what targets it.
  always_comb begin
    data = file_data;
    src  = FILE;
    if (hit[HIT_ZERO]) begin
      data = '0;
      src  = ZERO;
    end else if (hit[HIT_EX]) begin
      data = ex_data;
      src  = EX;
    end else if (hit[HIT_MM]) begin
      data = mm_data;
      src  = MM;
    end else if (hit[HIT_MEM]) begin
      data = mem_data;
      src  = MEM;
    end else if (hit[HIT_WB]) begin
      data = wb_data;
      src  = WB;
    end
  end

endmodule

// File: rtl/forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
// Operand forwarding and load scoreboard for an in-order pipeline.
// Each read port takes its operand from the youngest matching producer or
// the register file; a busy bit per register tracks loads still in flight,
// and decode is stalled when an operand depends on an unreturned load or on
// a load currently in EX (load-use).
// Optional feature:
//   FORWARD_UNIT_WB_BYPASS_EN  defined -> WB stage is a forwarding source;
//                              undefined -> wb_* ignored, register file is
//                              assumed write-before-read.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   rs_idx, rs_used, file_data      per-port source index, live flag, RF data
//   ex_wr_en/ex_is_load/ex_rd/ex_data   EX-stage producer
//   mm_wr_en/mm_rd/mm_data          MM-stage ALU producer
//   wb_wr_en/wb_rd/wb_data          WB-stage producer
//   ld_issue_valid/ld_issue_rd      load issued to memory
//   ld_issue_ready                  a load may be accepted
//   mem_resp_valid/mem_resp_rd/mem_resp_data   load data return
//   rs_data                         forwarded operand per port
//   stall                           hold decode this cycle
//   out_cnt                         outstanding load count
//   resp_err                        sticky: response with no load outstanding
// Multi-port buses are flattened, port p occupying slice [p*W +: W].
// ---------------------------------------------------------------------------
module forward_unit
  import forward_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int REG_NUM    = DEFAULT_REG_NUM,
  parameter int NUM_RS     = DEFAULT_NUM_RS,
  parameter int MAX_OUT    = DEFAULT_MAX_OUT,
  localparam int RW        = $clog2(REG_NUM),
  localparam int CW        = $clog2(MAX_OUT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RS*RW-1:0]         rs_idx,
  input  logic [NUM_RS-1:0]            rs_used,
  input  logic [NUM_RS*DATA_WIDTH-1:0] file_data,
  input  logic                         ex_wr_en,
  input  logic                         ex_is_load,
  input  logic [RW-1:0]                ex_rd,
  input  logic [DATA_WIDTH-1:0]        ex_data,
  input  logic                         mm_wr_en,
  input  logic [RW-1:0]                mm_rd,
  input  logic [DATA_WIDTH-1:0]        mm_data,
  input  logic                         wb_wr_en,
  input  logic [RW-1:0]                wb_rd,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  input  logic                         ld_issue_valid,
  input  logic [RW-1:0]                ld_issue_rd,
  output logic                         ld_issue_ready,
  input  logic                         mem_resp_valid,
  input  logic [RW-1:0]                mem_resp_rd,
  input  logic [DATA_WIDTH-1:0]        mem_resp_data,
  output logic [NUM_RS*DATA_WIDTH-1:0] rs_data,
  output logic                         stall,
  output logic [CW-1:0]                out_cnt,
  output logic                         resp_err
);

  logic [REG_NUM-1:0]    busy_q;
  logic [REG_NUM-1:0]    busy_d;
  logic [CW-1:0]         cnt_d;
  logic                  err_d;
  logic                  issue_acc;
  logic [NUM_RS-1:0]     port_stall;
  logic [DATA_WIDTH-1:0] wb_fwd_data;

`ifdef FORWARD_UNIT_WB_BYPASS_EN
  assign wb_fwd_data = wb_data;
`else
  // WB inputs have no effect in this build; fold them into a sink net.
  logic unused_wb;
  assign unused_wb   = ^{wb_wr_en, wb_rd, wb_data};
  assign wb_fwd_data = '0;
`endif

  assign ld_issue_ready = (out_cnt < CW'(MAX_OUT));
  assign issue_acc      = ld_issue_valid & ld_issue_ready;

  // Per-port match decode, operand selection and stall detection
  for (genvar p = 0; p < NUM_RS; p++) begin : g_port
    logic [RW-1:0]       rs;
    logic [NUM_HITS-1:0] hit;
    logic                load_use;
    fwd_src_t            src;
    logic                unused_src;

    assign rs            = rs_idx[p*RW +: RW];
    assign hit[HIT_ZERO] = (rs == '0);
    assign hit[HIT_EX]   = ex_wr_en & ~ex_is_load & (ex_rd == rs);
    assign hit[HIT_MM]   = mm_wr_en & (mm_rd == rs);
    assign hit[HIT_MEM]  = mem_resp_valid & (mem_resp_rd == rs);
`ifdef FORWARD_UNIT_WB_BYPASS_EN
    assign hit[HIT_WB]   = wb_wr_en & (wb_rd == rs);
`else
    assign hit[HIT_WB]   = 1'b0;
`endif
    assign load_use      = ex_wr_en & ex_is_load & (ex_rd == rs);

    fwd_port_sel #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_sel (
      .hit       (hit),
      .ex_data   (ex_data),
      .mm_data   (mm_data),
      .mem_data  (mem_resp_data),
      .wb_data   (wb_fwd_data),
      .file_data (file_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .data      (rs_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .src       (src)
    );

    // The selected source is debug visibility only.
    assign unused_src = ^src;

    // A busy register whose load data is returning this very cycle is
    // forwarded from the response instead of stalling.
    assign port_stall[p] = rs_used[p] & ~hit[HIT_ZERO] &
                           ((busy_q[rs] & ~hit[HIT_MEM]) | load_use);
  end

  assign stall = |port_stall;

  // Scoreboard next state: clear on response, then set on accepted issue so
  // that a same-register set/clear collision leaves the register busy.
  always_comb begin
    busy_d = busy_q;
    if (mem_resp_valid) begin
      busy_d[mem_resp_rd] = 1'b0;
    end
    if (issue_acc && (ld_issue_rd != '0)) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Outstanding count: issue and response in the same cycle cancel; a
  // response with nothing outstanding is flagged instead of underflowing.
  always_comb begin
    cnt_d = out_cnt;
    err_d = resp_err;
    if (issue_acc && !mem_resp_valid) begin
      cnt_d = out_cnt + CW'(1);
    end else if (!issue_acc && mem_resp_valid) begin
      if (out_cnt == '0) begin
        err_d = 1'b1;
      end else begin
        cnt_d = out_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      out_cnt  <= '0;
      resp_err <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      out_cnt  <= cnt_d;
      resp_err <= err_d;
    end
  end

endmodule

// File: tb/tb_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_forward_unit
// Self-checking bench for forward_unit with default parameters. Directed
// scenarios check fixed expected values; a randomized run compares against
// a behavioural model of the forwarding priority, scoreboard and counter.
// Honours FORWARD_UNIT_WB_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_forward_unit;

  localparam int DW  = 64;
  localparam int RN  = 32;
  localparam int NRS = 2;
  localparam int MO  = 4;
  localparam int RW  = 5;
  localparam int CW  = 3;

  logic              clk;
  logic              rst;
  logic [NRS*RW-1:0] rs_idx;
  logic [NRS-1:0]    rs_used;
  logic [NRS*DW-1:0] file_data;
  logic              ex_wr_en, ex_is_load;
  logic [RW-1:0]     ex_rd;
  logic [DW-1:0]     ex_data;
  logic              mm_wr_en;
  logic [RW-1:0]     mm_rd;
  logic [DW-1:0]     mm_data;
  logic              wb_wr_en;
  logic [RW-1:0]     wb_rd;
  logic [DW-1:0]     wb_data;
  logic              ld_issue_valid;
  logic [RW-1:0]     ld_issue_rd;
  logic              ld_issue_ready;
  logic              mem_resp_valid;
  logic [RW-1:0]     mem_resp_rd;
  logic [DW-1:0]     mem_resp_data;
  logic [NRS*DW-1:0] rs_data;
  logic              stall;
  logic [CW-1:0]     out_cnt;
  logic              resp_err;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  bit [RN-1:0] m_busy;
  int          m_cnt;
  bit          m_err;

  forward_unit #(
    .DATA_WIDTH (DW),
    .REG_NUM    (RN),
    .NUM_RS     (NRS),
    .MAX_OUT    (MO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rs_idx         (rs_idx),
    .rs_used        (rs_used),
    .file_data      (file_data),
    .ex_wr_en       (ex_wr_en),
    .ex_is_load     (ex_is_load),
    .ex_rd          (ex_rd),
    .ex_data        (ex_data),
    .mm_wr_en       (mm_wr_en),
    .mm_rd          (mm_rd),
    .mm_data        (mm_data),
    .wb_wr_en       (wb_wr_en),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_rd    (ld_issue_rd),
    .ld_issue_ready (ld_issue_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rd    (mem_resp_rd),
    .mem_resp_data  (mem_resp_data),
    .rs_data        (rs_data),
    .stall          (stall),
    .out_cnt        (out_cnt),
    .resp_err       (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    rs_idx         = '0;
    rs_used        = '0;
    file_data      = {64'hF1F1_F1F1_F1F1_F1F1, 64'hF0F0_F0F0_F0F0_F0F0};
    ex_wr_en       = 1'b0;
    ex_is_load     = 1'b0;
    ex_rd          = '0;
    ex_data        = '0;
    mm_wr_en       = 1'b0;
    mm_rd          = '0;
    mm_data        = '0;
    wb_wr_en       = 1'b0;
    wb_rd          = '0;
    wb_data        = '0;
    ld_issue_valid = 1'b0;
    ld_issue_rd    = '0;
    mem_resp_valid = 1'b0;
    mem_resp_rd    = '0;
    mem_resp_data  = '0;
  endtask

  // Model of the clocked effects: what happens to the load bookkeeping when
  // the current inputs are captured by a rising edge.
  task automatic model_update();
    bit accepted;
    if (rst) begin
      m_busy = '0;
      m_cnt  = 0;
      m_err  = 1'b0;
    end else begin
      accepted = ld_issue_valid && (m_cnt < MO);
      if (mem_resp_valid) m_busy[mem_resp_rd] = 1'b0;
      if (accepted && ld_issue_rd != 0) m_busy[ld_issue_rd] = 1'b1;
      if (accepted && !mem_resp_valid) m_cnt = m_cnt + 1;
      else if (!accepted && mem_resp_valid) begin
        if (m_cnt == 0) m_err = 1'b1;
        else m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [DW-1:0] exp_data(int p);
    logic [RW-1:0] r;
    r = rs_idx[p*RW +: RW];
    if (r == 0) return '0;
    if (ex_wr_en && !ex_is_load && ex_rd == r) return ex_data;
    if (mm_wr_en && mm_rd == r) return mm_data;
    if (mem_resp_valid && mem_resp_rd == r) return mem_resp_data;
`ifdef FORWARD_UNIT_WB_BYPASS_EN
    if (wb_wr_en && wb_rd == r) return wb_data;
`endif
    return file_data[p*DW +: DW];
  endfunction

  function automatic logic exp_stall();
    logic [RW-1:0] r;
    for (int p = 0; p < NRS; p++) begin
      r = rs_idx[p*RW +: RW];
      if (rs_used[p] && r != 0) begin
        if (m_busy[r] && !(mem_resp_valid && mem_resp_rd == r)) return 1'b1;
        if (ex_wr_en && ex_is_load && ex_rd == r) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    do_reset();
    n_checks++;
    if (out_cnt !== 3'd0) begin
      n_fails++; $display("[TB] FAIL reset_out_cnt: got %0d expected 0", out_cnt);
    end
    n_checks++;
    if (resp_err !== 1'b0) begin
      n_fails++; $display("[TB] FAIL reset_resp_err: got %0b expected 0", resp_err);
    end
    n_checks++;
    if (ld_issue_ready !== 1'b1) begin
      n_fails++; $display("[TB] FAIL reset_ready: got %0b expected 1", ld_issue_ready);
    end
    rs_used = 2'b11;
    rs_idx  = {5'd3, 5'd4};
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fails++; $display("[TB] FAIL reset_no_stall: got %0b expected 0", stall);
    end
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fails++; $display("[TB] FAIL reset_load_use: got %0b expected 1", stall);
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    $display("[TB] test_priority");
    do_reset();
    rs_used = 2'b01;
    rs_idx[0 +: RW] = 5'd5;
    ex_wr_en = 1'b1; ex_rd = 5'd5; ex_data = 64'hAA;
    mm_wr_en = 1'b1; mm_rd = 5'd5; mm_data = 64'hBB;
    #1;
    n_checks++;
    if (rs_data[0 +: DW] !== 64'hAA) begin
      n_fails++; $display("[TB] FAIL prio_ex_over_mm: got %0h expected aa", rs_data[0 +: DW]);
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_fails++; $display("[TB] FAIL prio_stall: got %0b expected 0", stall);
    end
    // A load in EX is not a forwarding source; MM supplies the value.
    ex_is_load = 1'b1;
    #1;
    n_checks++;
    if (rs_data[0 +: DW] !== 64'hBB) begin
      n_fails++; $display("[TB] FAIL prio_mm_when_ex_load: got %0h expected bb", rs_data[0 +: DW]);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    $display("[TB] test_load_use");
    do_reset();
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
    tick();
    ld_issue_valid = 1'b0;
    rs_used = 2'b10;
    rs_idx[RW +: RW] = 5'd7;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fails++; $display("[TB] FAIL busy_stall: got %0b expected 1", stall);
    end
    mem_resp_valid = 1'b1; mem_resp_rd = 5'd7; mem_resp_data = 64'h1234;
    #1;
    n_checks++;
    if (rs_data[DW +: DW] !== 64'h1234) begin
      n_fails++; $display("[TB] FAIL resp_forward: got %0h expected 1234", rs_data[DW +: DW]);
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_fails++; $display("[TB] FAIL resp_unstall: got %0b expected 0", stall);
    end
    tick();
    mem_resp_valid = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fails++; $display("[TB] FAIL busy_cleared: got %0b expected 0", stall);
    end
    n_checks++;
    if (rs_data[DW +: DW] !== 64'hF1F1_F1F1_F1F1_F1F1) begin
      n_fails++; $display("[TB] FAIL file_fallback: got %0h expected f1f1f1f1f1f1f1f1", rs_data[DW +: DW]);
    end
    clear_inputs();
  endtask

  task automatic test_max_out();
    $display("[TB] test_max_out");
    do_reset();
    for (int i = 1; i <= MO; i++) begin
      ld_issue_valid = 1'b1; ld_issue_rd = 5'(i);
      tick();
    end
    n_checks++;
    if (out_cnt !== 3'd4) begin
      n_fails++; $display("[TB] FAIL full_cnt: got %0d expected 4", out_cnt);
    end
    n_checks++;
    if (ld_issue_ready !== 1'b0) begin
      n_fails++; $display("[TB] FAIL full_ready: got %0b expected 0", ld_issue_ready);
    end
    // Issue while full is ignored: count and scoreboard unchanged.
    ld_issue_rd = 5'd10;
    tick();
    ld_issue_valid = 1'b0;
    rs_used = 2'b01;
    rs_idx[0 +: RW] = 5'd10;
    #1;
    n_checks++;
    if (out_cnt !== 3'd4 || stall !== 1'b0) begin
      n_fails++; $display("[TB] FAIL full_ignore: got cnt %0d stall %0b expected cnt 4 stall 0", out_cnt, stall);
    end
    mem_resp_valid = 1'b1; mem_resp_rd = 5'd1;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    n_checks++;
    if (out_cnt !== 3'd3 || ld_issue_ready !== 1'b1) begin
      n_fails++; $display("[TB] FAIL drain_one: got cnt %0d ready %0b expected cnt 3 ready 1", out_cnt, ld_issue_ready);
    end
    clear_inputs();
  endtask

  task automatic test_zero_reg();
    $display("[TB] test_zero_reg");
    do_reset();
    rs_used = 2'b11;
    rs_idx  = '0;
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = '0; ex_data = 64'h11;
    mm_wr_en = 1'b1; mm_rd = '0; mm_data = 64'h22;
    #1;
    n_checks++;
    if (rs_data !== '0 || stall !== 1'b0) begin
      n_fails++; $display("[TB] FAIL zero_reg: got data %0h stall %0b expected 0 0", rs_data, stall);
    end
    ex_wr_en = 1'b0; mm_wr_en = 1'b0;
    ld_issue_valid = 1'b1; ld_issue_rd = '0;
    tick();
    ld_issue_valid = 1'b0;
    #1;
    n_checks++;
    if (out_cnt !== 3'd1 || stall !== 1'b0) begin
      n_fails++; $display("[TB] FAIL zero_issue: got cnt %0d stall %0b expected 1 0", out_cnt, stall);
    end
    clear_inputs();
  endtask

  task automatic test_resp_err();
    $display("[TB] test_resp_err");
    do_reset();
    mem_resp_valid = 1'b1; mem_resp_rd = 5'd3;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    n_checks++;
    if (resp_err !== 1'b1 || out_cnt !== 3'd0) begin
      n_fails++; $display("[TB] FAIL err_sticky: got err %0b cnt %0d expected 1 0", resp_err, out_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (resp_err !== 1'b0 || out_cnt !== 3'd0) begin
      n_fails++; $display("[TB] FAIL err_reset: got err %0b cnt %0d expected 0 0", resp_err, out_cnt);
    end
    // Reset mid-flight discards the outstanding load.
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd6;
    tick();
    ld_issue_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rs_used = 2'b01; rs_idx[0 +: RW] = 5'd6;
    #1;
    n_checks++;
    if (stall !== 1'b0 || out_cnt !== 3'd0) begin
      n_fails++; $display("[TB] FAIL midreset: got stall %0b cnt %0d expected 0 0", stall, out_cnt);
    end
    mem_resp_valid = 1'b1; mem_resp_rd = 5'd6;
    tick();
    mem_resp_valid = 1'b0;
    n_checks++;
    if (resp_err !== 1'b1) begin
      n_fails++; $display("[TB] FAIL late_resp_err: got %0b expected 1", resp_err);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    do_reset();
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd2;
    tick();
    ld_issue_rd = 5'd9;
    mem_resp_valid = 1'b1; mem_resp_rd = 5'd9;
    tick();
    ld_issue_valid = 1'b0; mem_resp_valid = 1'b0;
    rs_used = 2'b01; rs_idx[0 +: RW] = 5'd9;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fails++; $display("[TB] FAIL set_wins: got stall %0b expected 1", stall);
    end
    n_checks++;
    if (out_cnt !== 3'd1) begin
      n_fails++; $display("[TB] FAIL cnt_unchanged: got %0d expected 1", out_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    $display("[TB] test_random");
    do_reset();
    for (int it = 0; it < 600; it++) begin
      rst            = ($urandom_range(0, 79) == 0);
      rs_used        = 2'($urandom);
      rs_idx         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      file_data      = {$urandom, $urandom, $urandom, $urandom};
      ex_wr_en       = $urandom_range(0, 1) == 1;
      ex_is_load     = $urandom_range(0, 2) == 0;
      ex_rd          = 5'($urandom_range(0, 7));
      ex_data        = {$urandom, $urandom};
      mm_wr_en       = $urandom_range(0, 1) == 1;
      mm_rd          = 5'($urandom_range(0, 7));
      mm_data        = {$urandom, $urandom};
      wb_wr_en       = $urandom_range(0, 1) == 1;
      wb_rd          = 5'($urandom_range(0, 7));
      wb_data        = {$urandom, $urandom};
      ld_issue_valid = $urandom_range(0, 1) == 1;
      ld_issue_rd    = 5'($urandom_range(0, 7));
      mem_resp_valid = $urandom_range(0, 2) == 0;
      mem_resp_rd    = 5'($urandom_range(0, 7));
      mem_resp_data  = {$urandom, $urandom};
      #1;
      for (int p = 0; p < NRS; p++) begin
        n_checks++;
        if (rs_data[p*DW +: DW] !== exp_data(p)) begin
          n_fails++;
          $display("[TB] FAIL rand_data[%0d] it %0d: got %0h expected %0h", p, it, rs_data[p*DW +: DW], exp_data(p));
        end
      end
      n_checks++;
      if (stall !== exp_stall()) begin
        n_fails++; $display("[TB] FAIL rand_stall it %0d: got %0b expected %0b", it, stall, exp_stall());
      end
      n_checks++;
      if (out_cnt !== CW'(m_cnt) || ld_issue_ready !== (m_cnt < MO)) begin
        n_fails++;
        $display("[TB] FAIL rand_cnt it %0d: got cnt %0d ready %0b expected cnt %0d ready %0b", it, out_cnt, ld_issue_ready, m_cnt, (m_cnt < MO));
      end
      n_checks++;
      if (resp_err !== m_err) begin
        n_fails++; $display("[TB] FAIL rand_err it %0d: got %0b expected %0b", it, resp_err, m_err);
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    m_busy = '0;
    m_cnt  = 0;
    m_err  = 1'b0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_priority();
    test_load_use();
    test_max_out();
    test_zero_reg();
    test_resp_err();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
